freq_scan_ctrl: RTL and testbench

Multi-channel frequency scan controller: time-shares one edge-counting measurement datapath across NCH asynchronous input signals. It selects each enabled channel in turn, waits for the synchronizer to settle and counts rising edges over a fixed gate window. It then stores a saturated count per channel and streams each result out. It sits in front of the frequency-display and readout logic, replacing one measurement module per input.

---
 rtl/freq_scan_ctrl_pkg.sv | 21 ++
 rtl/freq_scan_ctrl_edge_counter.sv | 52 +++++
 rtl/freq_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_freq_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/freq_scan_ctrl_pkg.sv
// freq_scan_ctrl_pkg
// Shared definitions for the frequency scan controller:
//   state_t  - FSM state encoding (IDLE=0, SETTLE=1, GATE=2, STORE=3)
//   max_int  - elaboration-time helper for sizing the window counter
`timescale 1ns/1ps
package freq_scan_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_STORE  = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/freq_scan_ctrl_edge_counter.sv
// freq_scan_ctrl_edge_counter
// Synchronizes one (already muxed) asynchronous signal, detects rising edges
// and counts them into a saturating CW-bit counter.
// Ports:
//   clk, rst_n  - system clock, async active-low reset
//   sig         - asynchronous input
//   clear       - holds the counter at zero (has priority over enable)
//   enable      - counting window open
//   count_next  - value the counter takes at the next clock edge
`timescale 1ns/1ps
module freq_scan_ctrl_edge_counter #(
  parameter int CW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sig,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count_next
);

  logic          sync1;
  logic          sync2;
  logic          hist;
  logic          edge_det;
  logic [CW-1:0] count;

  assign edge_det = sync2 & ~hist;

  always_comb begin
    count_next = count;
    if (clear)
      count_next = '0;
    else if (enable && edge_det && (count != '1))
      count_next = count + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      count <= '0;
    end else begin
      sync1 <= sig;
      sync2 <= sync1;
      hist  <= sync2;
      count <= count_next;
    end
  end

endmodule

// File: rtl/freq_scan_ctrl.sv
// freq_scan_ctrl
// Time-shares one edge-counting datapath across NCH asynchronous inputs:
// settles on each enabled channel, counts rising edges over a fixed gate
// window, stores a saturated count per channel and streams it out.
// Ports:
//   clk, rst_n     - system clock, async active-low reset
//   run            - 1 = scan continuously, 0 = stop/abort
//   ch_mask        - channel enables
//   sig_in         - asynchronous input signals
//   rd_ch/rd_data  - registered result readback (with write bypass)
//   cur_ch, busy   - scan status
//   meas_valid, meas_ch, meas_freq - per-measurement result stream
//   sweep_done     - pulse with the last enabled channel's meas_valid
//
// state  | meaning
// IDLE   | waiting for run with a non-zero mask
// SETTLE | synchronizer flushing after a channel switch, counter held at 0
// GATE   | counting rising edges for GATE_CYCLES cycles
// STORE  | result written and presented, next channel picked
`timescale 1ns/1ps
module freq_scan_ctrl
  import freq_scan_ctrl_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int CW            = 14,
  parameter int GATE_CYCLES   = 10000,
  parameter int SETTLE_CYCLES = 4,
  localparam int CHW          = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [NCH-1:0] ch_mask,
  input  logic [NCH-1:0] sig_in,
  input  logic [CHW-1:0] rd_ch,
  output logic [CW-1:0]  rd_data,
  output logic [CHW-1:0] cur_ch,
  output logic           busy,
  output logic           meas_valid,
  output logic [CHW-1:0] meas_ch,
  output logic [CW-1:0]  meas_freq,
  output logic           sweep_done
);

  localparam int WIN_W = $clog2(max_int(GATE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYCLES - 1);
  localparam logic [WIN_W-1:0] GATE_LOAD   = WIN_W'(GATE_CYCLES - 1);

  state_t         state;
  logic [WIN_W-1:0] win;
  logic [CW-1:0]  count_next;
  logic           gate_end;
  logic [CW-1:0]  result [NCH];

  function automatic logic [CHW-1:0] lowest_ch(input logic [NCH-1:0] mask);
    lowest_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (mask[i]) lowest_ch = CHW'(i);
  endfunction

  function automatic logic has_above(input logic [NCH-1:0] mask, input logic [CHW-1:0] cur);
    has_above = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (mask[i] && (i > int'(cur))) has_above = 1'b1;
  endfunction

  function automatic logic [CHW-1:0] next_ch(input logic [NCH-1:0] mask, input logic [CHW-1:0] cur);
    next_ch = lowest_ch(mask);
    for (int i = NCH - 1; i >= 0; i--)
      if (mask[i] && (i > int'(cur))) next_ch = CHW'(i);
  endfunction

  freq_scan_ctrl_edge_counter #(.CW(CW)) u_edge_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig        (sig_in[cur_ch]),
    .clear      (state != ST_GATE),
    .enable     (state == ST_GATE),
    .count_next (count_next)
  );

  // Last gate cycle with run still high: count_next already includes the
  // final cycle's edge, so the result is captured on entry to STORE and is
  // visible for the whole STORE cycle.
  assign gate_end = (state == ST_GATE) && run && (win == '0);

  assign busy = (state != ST_IDLE);

  // Mask is looked at during STORE itself, where meas_valid is high and
  // meas_ch equals the channel just measured.
  assign sweep_done = meas_valid && !has_above(ch_mask, meas_ch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      win        <= '0;
      cur_ch     <= '0;
      meas_valid <= 1'b0;
      meas_ch    <= '0;
      meas_freq  <= '0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run && (|ch_mask)) begin
            cur_ch <= lowest_ch(ch_mask);
            win    <= SETTLE_LOAD;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!run) begin
            state <= ST_IDLE;
          end else if (win == '0) begin
            win   <= GATE_LOAD;
            state <= ST_GATE;
          end else begin
            win <= win - WIN_W'(1);
          end
        end
        ST_GATE: begin
          if (!run) begin
            state <= ST_IDLE;
          end else if (gate_end) begin
            meas_valid <= 1'b1;
            meas_ch    <= cur_ch;
            meas_freq  <= count_next;
            state      <= ST_STORE;
          end else begin
            win <= win - WIN_W'(1);
          end
        end
        ST_STORE: begin
          if (!run || (ch_mask == '0)) begin
            state <= ST_IDLE;
          end else begin
            cur_ch <= next_ch(ch_mask, cur_ch);
            win    <= SETTLE_LOAD;
            state  <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) result[i] <= '0;
      rd_data <= '0;
    end else begin
      if (gate_end) result[cur_ch] <= count_next;
      if (gate_end && (cur_ch == rd_ch))
        rd_data <= count_next;
      else
        rd_data <= result[rd_ch];
    end
  end

endmodule

// File: tb/tb_freq_scan_ctrl.sv
`timescale 1ns/1ps
module tb_freq_scan_ctrl;

  localparam int NCH    = 4;
  localparam int CW     = 6;
  localparam int GATE   = 200;
  localparam int SETTLE = 4;
  localparam int PER    = SETTLE + GATE + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic [1:0]    rd_ch = '0;
  logic [NCH-1:0] sig_in;
  logic [CW-1:0] rd_data;
  logic [1:0]    cur_ch;
  logic          busy;
  logic          meas_valid;
  logic [1:0]    meas_ch;
  logic [CW-1:0] meas_freq;
  logic          sweep_done;

  logic s0 = 1'b0;
  logic s1 = 1'b0;
  logic s2 = 1'b0;

  int tests = 0;
  int fails = 0;

  assign sig_in = {1'b0, s2, s1, s0};

  freq_scan_ctrl #(
    .NCH(NCH), .CW(CW), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ch_mask(ch_mask), .sig_in(sig_in),
    .rd_ch(rd_ch), .rd_data(rd_data), .cur_ch(cur_ch), .busy(busy),
    .meas_valid(meas_valid), .meas_ch(meas_ch), .meas_freq(meas_freq),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;
  // ch0: period 34 ns, ch1: period 40 ns (4 clk), ch2: period 20 ns (2 clk), ch3: 0
  initial forever #17 s0 = ~s0;
  initial forever #20 s1 = ~s1;
  initial forever #10 s2 = ~s2;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_valid(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (meas_valid) ok = 1'b1;
    end
  endtask

  task automatic stop_scan();
    run = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (meas_valid !== 1'b0) begin fails++; $display("FAIL reset_meas_valid got %0b want 0", meas_valid); end
    tests++; if (sweep_done !== 1'b0) begin fails++; $display("FAIL reset_sweep_done got %0b want 0", sweep_done); end
    tests++; if (cur_ch !== 2'd0) begin fails++; $display("FAIL reset_cur_ch got %0d want 0", cur_ch); end
    tests++; if ({meas_ch, meas_freq} !== '0) begin fails++; $display("FAIL reset_meas got ch %0d freq %0d want 0 0", meas_ch, meas_freq); end
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
  endtask

  task automatic test_mask_zero();
    bit seen = 1'b0;
    ch_mask = 4'b0000;
    run = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (meas_valid || busy) seen = 1'b1;
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mask_zero_busy got %0b want 0", busy); end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mask_zero_activity got %0b want 0", seen); end
    stop_scan();
  endtask

  task automatic test_single_channel();
    int cyc; bit ok;
    ch_mask = 4'b0001;
    rd_ch = 2'd0;
    run = 1'b1;
    wait_valid(PER + 10, cyc, ok);
    tests++; if (!ok || cyc != PER) begin fails++; $display("FAIL single_latency got %0d ok %0b want %0d", cyc, ok, PER); end
    tests++; if (meas_ch !== 2'd0) begin fails++; $display("FAIL single_ch got %0d want 0", meas_ch); end
    tests++; if (meas_freq < 58 || meas_freq > 59) begin fails++; $display("FAIL single_freq got %0d want 58..59", meas_freq); end
    tests++; if (sweep_done !== 1'b1) begin fails++; $display("FAIL single_sweep got %0b want 1", sweep_done); end
    @(negedge clk);
    tests++; if (meas_valid !== 1'b0) begin fails++; $display("FAIL single_pulse_width got %0b want 0", meas_valid); end
    tests++; if (rd_data < 58 || rd_data > 59) begin fails++; $display("FAIL single_rd_data got %0d want 58..59", rd_data); end
    wait_valid(PER + 10, cyc, ok);
    tests++; if (!ok || cyc != PER - 1) begin fails++; $display("FAIL single_period got %0d ok %0b want %0d", cyc, ok, PER - 1); end
    tests++; if (meas_freq < 58 || meas_freq > 59 || sweep_done !== 1'b1) begin fails++; $display("FAIL single_second got freq %0d sweep %0b want 58..59 1", meas_freq, sweep_done); end
    stop_scan();
  endtask

  task automatic test_multi_channel();
    int cyc; bit ok;
    logic [1:0] order [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
    ch_mask = 4'b1011;
    rd_ch = 2'd1;
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(PER + 10, cyc, ok);
      tests++; if (!ok || cyc != PER) begin fails++; $display("FAIL multi_gap[%0d] got %0d ok %0b want %0d", k, cyc, ok, PER); end
      tests++; if (meas_ch !== order[k]) begin fails++; $display("FAIL multi_order[%0d] got %0d want %0d", k, meas_ch, order[k]); end
      tests++; if (sweep_done !== (order[k] == 2'd3)) begin fails++; $display("FAIL multi_sweep[%0d] got %0b want %0b", k, sweep_done, order[k] == 2'd3); end
      case (order[k])
        2'd0: begin tests++; if (meas_freq < 58 || meas_freq > 59) begin fails++; $display("FAIL multi_freq0 got %0d want 58..59", meas_freq); end end
        2'd1: begin tests++; if (meas_freq !== 6'd50) begin fails++; $display("FAIL multi_freq1 got %0d want 50", meas_freq); end end
        default: begin tests++; if (meas_freq !== 6'd0) begin fails++; $display("FAIL multi_freq3 got %0d want 0", meas_freq); end end
      endcase
    end
    stop_scan();
    tests++; if (rd_data !== 6'd50) begin fails++; $display("FAIL multi_readback1 got %0d want 50", rd_data); end
  endtask

  task automatic test_saturate();
    int cyc; bit ok;
    ch_mask = 4'b0100;
    rd_ch = 2'd2;
    run = 1'b1;
    wait_valid(PER + 10, cyc, ok);
    tests++; if (!ok || cyc != PER) begin fails++; $display("FAIL sat_latency got %0d ok %0b want %0d", cyc, ok, PER); end
    tests++; if (meas_freq !== 6'd63 || meas_ch !== 2'd2) begin fails++; $display("FAIL sat_freq got %0d ch %0d want 63 2", meas_freq, meas_ch); end
    tests++; if (sweep_done !== 1'b1) begin fails++; $display("FAIL sat_sweep got %0b want 1", sweep_done); end
    @(negedge clk);
    tests++; if (rd_data !== 6'd63) begin fails++; $display("FAIL sat_bypass got %0d want 63", rd_data); end
    stop_scan();
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    ch_mask = 4'b0010;
    rd_ch = 2'd1;
    run = 1'b1;
    repeat (100) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before got %0b want 1", busy); end
    run = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle got %0b want 0", busy); end
    repeat (300) begin
      @(negedge clk);
      if (meas_valid) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_valid got %0b want 0", seen); end
    tests++; if (rd_data !== 6'd50) begin fails++; $display("FAIL abort_result1 got %0d want 50", rd_data); end
    rd_ch = 2'd2;
    repeat (2) @(negedge clk);
    tests++; if (rd_data !== 6'd63) begin fails++; $display("FAIL abort_result2 got %0d want 63", rd_data); end
  endtask

  task automatic test_reset_mid_gate();
    int cyc; bit ok;
    ch_mask = 4'b0001;
    rd_ch = 2'd2;
    run = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    run = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || cur_ch !== 2'd0) begin fails++; $display("FAIL rstmid_state got busy %0b cur %0d want 0 0", busy, cur_ch); end
    tests++; if (meas_freq !== '0 || meas_ch !== 2'd0 || meas_valid !== 1'b0) begin fails++; $display("FAIL rstmid_meas got freq %0d ch %0d valid %0b want 0", meas_freq, meas_ch, meas_valid); end
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL rstmid_rd_data got %0d want 0", rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL rstmid_result2 got %0d want 0", rd_data); end
    rd_ch = 2'd0;
    run = 1'b1;
    wait_valid(PER + 10, cyc, ok);
    tests++; if (!ok || cyc != PER) begin fails++; $display("FAIL rstmid_rerun_latency got %0d ok %0b want %0d", cyc, ok, PER); end
    tests++; if (meas_ch !== 2'd0 || meas_freq < 58 || meas_freq > 59) begin fails++; $display("FAIL rstmid_rerun got ch %0d freq %0d want 0 58..59", meas_ch, meas_freq); end
    stop_scan();
  endtask

  initial begin
    test_reset();
    test_mask_zero();
    test_single_channel();
    test_multi_channel();
    test_saturate();
    test_abort();
    test_reset_mid_gate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
